// File: rtl/data_mem_resp.sv
// Word-addressed data memory behind a fixed wait-state request/ready handshake.
// Each accepted load/store completes with a one-cycle ready pulse; misaligned accesses are flagged and dropped.
module data_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        misalign
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] cap_idx;
  logic [1:0]    cap_off;
  logic          cap_wr;
  logic [31:0]   cap_wdata;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_off;
  logic          acc_wr;
  logic [31:0]   acc_wdata;
  logic          enter_done;
  logic          unused_adr;

  // Upper address bits are deliberately dropped so addresses wrap.
  assign unused_adr = ^adr[31:AW+2];

  // Operands of the access completing on this edge; with no wait states the
  // accept edge is also the completing edge, so they come straight from the inputs.
  always_comb begin
    req        = mem_read | mem_write;
    acc_idx    = cap_idx;
    acc_off    = cap_off;
    acc_wr     = cap_wr;
    acc_wdata  = cap_wdata;
    enter_done = 1'b0;
    if (state == IDLE) begin
      acc_idx    = adr[AW+1:2];
      acc_off    = adr[1:0];
      acc_wr     = mem_write;
      acc_wdata  = wdata;
      enter_done = req && (WAIT == 0);
    end else if (state == BUSY) begin
      enter_done = (cnt == '0);
    end
  end

  // Control FSM, registered outputs and array; the array is never reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_off   <= '0;
      cap_wr    <= 1'b0;
      cap_wdata <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      ready    <= enter_done;
      misalign <= enter_done && (acc_off != 2'b00);
      if (enter_done && !acc_wr) begin
        rdata <= (acc_off == 2'b00) ? mem[acc_idx] : 32'h0;
      end
      if (enter_done && acc_wr && (acc_off == 2'b00)) begin
        mem[acc_idx] <= acc_wdata;
      end
      case (state)
        IDLE: begin
          if (req) begin
            cap_idx   <= adr[AW+1:2];
            cap_off   <= adr[1:0];
            cap_wr    <= mem_write;
            cap_wdata <= wdata;
            if (WAIT == 0) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= CW'(WAIT - 1);
            end
          end
        end
        BUSY: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: one WAIT=0 and one WAIT=2 instance
// checked against a word-array reference model with randomized traffic.
module tb_data_mem_resp;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr_s [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        rd_s [2];
  logic        wr_s [2];
  logic        ready_s [2];
  logic        mis_s [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [2][256];
  bit          ref_vld [2][256];
  logic [31:0] ref_rd [2];
  bit          ref_rd_known [2];

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH_WORDS(256), .WAIT(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .adr(adr_s[0]), .wdata(wdata_s[0]),
    .mem_read(rd_s[0]), .mem_write(wr_s[0]),
    .rdata(rdata_s[0]), .ready(ready_s[0]), .misalign(mis_s[0])
  );

  data_mem_resp #(.DEPTH_WORDS(256), .WAIT(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .adr(adr_s[1]), .wdata(wdata_s[1]),
    .mem_read(rd_s[1]), .mem_write(wr_s[1]),
    .rdata(rdata_s[1]), .ready(ready_s[1]), .misalign(mis_s[1])
  );

  function automatic int wait_of(input int w);
    return (w == 0) ? 0 : 2;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  // Reference: byte address -> word slot modulo the array, write wins over read.
  task automatic model_access(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                              output logic exp_mis, output logic [31:0] exp_rd, output bit rd_known);
    int i;
    i = widx(a);
    exp_mis = ((a % 4) != 0);
    if (wr) begin
      if (!exp_mis) begin
        ref_mem[w][i] = d;
        ref_vld[w][i] = 1'b1;
      end
    end else if (exp_mis) begin
      ref_rd[w]       = 32'h0;
      ref_rd_known[w] = 1'b1;
    end else begin
      ref_rd[w]       = ref_mem[w][i];
      ref_rd_known[w] = ref_vld[w][i];
    end
    exp_rd   = ref_rd[w];
    rd_known = ref_rd_known[w];
  endtask

  // Issue one request, scramble adr/wdata while it is in flight, report what came back.
  task automatic access(input int w, input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd_o,
                        output logic mis_o, output logic rdy_after);
    @(negedge clk);
    adr_s[w] = a; wdata_s[w] = d; wr_s[w] = wr; rd_s[w] = rd;
    @(posedge clk); #1;
    lat = 1;
    while (ready_s[w] !== 1'b1 && lat <= 40) begin
      adr_s[w] = $urandom; wdata_s[w] = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    if (lat > 40) lat = -1;
    rd_o  = rdata_s[w];
    mis_o = mis_s[w];
    wr_s[w] = 1'b0; rd_s[w] = 1'b0; adr_s[w] = $urandom; wdata_s[w] = $urandom;
    @(posedge clk); #1;
    rdy_after = ready_s[w];
  endtask

  task automatic test_reset();
    for (int w = 0; w < 2; w++) begin
      adr_s[w] = 32'h0; wdata_s[w] = 32'h0; rd_s[w] = 1'b0; wr_s[w] = 1'b0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      checks++; if (ready_s[w] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 0", w, ready_s[w]); end
      checks++; if (mis_s[w] !== 1'b0) begin errors++; $display("FAIL reset_misalign[%0d]: got %b want 0", w, mis_s[w]); end
      checks++; if (rdata_s[w] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", w, rdata_s[w]); end
      ref_rd[w] = 32'h0; ref_rd_known[w] = 1'b1;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] r; logic m, ra, em; logic [31:0] er; bit ek;
    access(1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, lat, r, m, ra);
    model_access(1, 1'b1, 32'h10, 32'hDEADBEEF, em, er, ek);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_wr_latency: got %0d want 3", lat); end
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL basic_wr_misalign: got %b want 0", m); end
    checks++; if (ra !== 1'b0) begin errors++; $display("FAIL basic_ready_after_done: got %b want 0", ra); end
    access(1, 1'b0, 1'b1, 32'h10, 32'h0, lat, r, m, ra);
    model_access(1, 1'b0, 32'h10, 32'h0, em, er, ek);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_rd_latency: got %0d want 3", lat); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h want deadbeef", r); end
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL basic_rd_misalign: got %b want 0", m); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] r, v0, v1; logic m, ra, em; logic [31:0] er; bit ek;
    v0 = $urandom; v1 = $urandom;
    access(0, 1'b1, 1'b0, 32'h0, v0, lat, r, m, ra);
    model_access(0, 1'b1, 32'h0, v0, em, er, ek);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_wr0_latency: got %0d want 1", lat); end
    access(0, 1'b1, 1'b0, 32'h4, v1, lat, r, m, ra);
    model_access(0, 1'b1, 32'h4, v1, em, er, ek);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_wr1_latency: got %0d want 1", lat); end
    @(negedge clk);
    adr_s[0] = 32'h0; rd_s[0] = 1'b1;
    @(posedge clk); #1;
    checks++; if (ready_s[0] !== 1'b1) begin errors++; $display("FAIL b2b_first_ready: got %b want 1", ready_s[0]); end
    checks++; if (rdata_s[0] !== v0) begin errors++; $display("FAIL b2b_first_data: got %h want %h", rdata_s[0], v0); end
    adr_s[0] = 32'h4;
    @(posedge clk); #1;
    checks++; if (ready_s[0] !== 1'b0) begin errors++; $display("FAIL b2b_gap_ready: got %b want 0", ready_s[0]); end
    @(posedge clk); #1;
    checks++; if (ready_s[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_ready: got %b want 1", ready_s[0]); end
    checks++; if (rdata_s[0] !== v1) begin errors++; $display("FAIL b2b_second_data: got %h want %h", rdata_s[0], v1); end
    rd_s[0] = 1'b0;
    @(posedge clk); #1;
    model_access(0, 1'b0, 32'h0, 32'h0, em, er, ek);
    model_access(0, 1'b0, 32'h4, 32'h0, em, er, ek);
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] r, v; logic m, ra, em; logic [31:0] er; bit ek;
    v = $urandom;
    access(1, 1'b1, 1'b0, 32'h20, v, lat, r, m, ra);
    model_access(1, 1'b1, 32'h20, v, em, er, ek);
    access(1, 1'b1, 1'b0, 32'h22, 32'h12345678, lat, r, m, ra);
    model_access(1, 1'b1, 32'h22, 32'h12345678, em, er, ek);
    checks++; if (lat !== 3) begin errors++; $display("FAIL mis_wr_latency: got %0d want 3", lat); end
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_wr_flag: got %b want 1", m); end
    access(1, 1'b0, 1'b1, 32'h20, 32'h0, lat, r, m, ra);
    model_access(1, 1'b0, 32'h20, 32'h0, em, er, ek);
    checks++; if (r !== v) begin errors++; $display("FAIL mis_word_unchanged: got %h want %h", r, v); end
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL mis_aligned_flag: got %b want 0", m); end
    access(1, 1'b0, 1'b1, 32'h23, 32'h0, lat, r, m, ra);
    model_access(1, 1'b0, 32'h23, 32'h0, em, er, ek);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mis_rd_data: got %h want 0", r); end
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_rd_flag: got %b want 1", m); end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] r; logic m, ra, em; logic [31:0] er; bit ek;
    access(1, 1'b1, 1'b0, 32'h400, 32'hA5A5A5A5, lat, r, m, ra);
    model_access(1, 1'b1, 32'h400, 32'hA5A5A5A5, em, er, ek);
    access(1, 1'b0, 1'b1, 32'h0, 32'h0, lat, r, m, ra);
    model_access(1, 1'b0, 32'h0, 32'h0, em, er, ek);
    checks++; if (r !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_data: got %h want a5a5a5a5", r); end
  endtask

  task automatic test_both_strobes();
    int lat; logic [31:0] r; logic m, ra, em; logic [31:0] er; bit ek;
    access(1, 1'b0, 1'b1, 32'h10, 32'h0, lat, r, m, ra);
    model_access(1, 1'b0, 32'h10, 32'h0, em, er, ek);
    access(1, 1'b1, 1'b1, 32'h8, 32'h55, lat, r, m, ra);
    model_access(1, 1'b1, 32'h8, 32'h55, em, er, ek);
    checks++; if (lat !== 3) begin errors++; $display("FAIL both_latency: got %0d want 3", lat); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL both_rdata_held: got %h want deadbeef", r); end
    access(1, 1'b0, 1'b1, 32'h8, 32'h0, lat, r, m, ra);
    model_access(1, 1'b0, 32'h8, 32'h0, em, er, ek);
    checks++; if (r !== 32'h55) begin errors++; $display("FAIL both_written: got %h want 55", r); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] r; logic m, ra, em; logic [31:0] er; bit ek; bit seen;
    access(1, 1'b1, 1'b0, 32'hC, 32'h1, lat, r, m, ra);
    model_access(1, 1'b1, 32'hC, 32'h1, em, er, ek);
    @(negedge clk);
    adr_s[1] = 32'hC; wdata_s[1] = 32'h2; wr_s[1] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; wr_s[1] = 1'b0;
    #1;
    checks++; if (ready_s[1] !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", ready_s[1]); end
    checks++; if (mis_s[1] !== 1'b0) begin errors++; $display("FAIL abort_misalign: got %b want 0", mis_s[1]); end
    checks++; if (rdata_s[1] !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h want 0", rdata_s[1]); end
    @(negedge clk);
    rst = 1'b1;
    for (int w = 0; w < 2; w++) begin ref_rd[w] = 32'h0; ref_rd_known[w] = 1'b1; end
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (ready_s[1] === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ready: got %b want 0", seen); end
    access(1, 1'b0, 1'b1, 32'hC, 32'h0, lat, r, m, ra);
    model_access(1, 1'b0, 32'hC, 32'h0, em, er, ek);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL abort_not_committed: got %h want 1", r); end
  endtask

  task automatic test_random();
    int lat, op; logic [31:0] a, d, r; logic m, ra, em, wr, rd; logic [31:0] er; bit ek;
    for (int w = 0; w < 2; w++) begin
      for (int n = 0; n < 40; n++) begin
        a = 32'($urandom_range(0, 3)) * 32'd1024 + 32'($urandom_range(0, 15)) * 32'd4;
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
        d  = $urandom;
        op = int'($urandom_range(0, 4));
        wr = (op <= 1) || (op == 4);
        rd = (op >= 2);
        access(w, wr, rd, a, d, lat, r, m, ra);
        model_access(w, wr, a, d, em, er, ek);
        checks++; if (lat !== wait_of(w) + 1) begin errors++; $display("FAIL rnd_latency[%0d]: adr %h got %0d want %0d", w, a, lat, wait_of(w) + 1); end
        checks++; if (m !== em) begin errors++; $display("FAIL rnd_misalign[%0d]: adr %h got %b want %b", w, a, m, em); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL rnd_ready_after[%0d]: got %b want 0", w, ra); end
        if (ek) begin
          checks++; if (r !== er) begin errors++; $display("FAIL rnd_rdata[%0d]: adr %h got %h want %h", w, a, r, er); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_misalign();
    test_wrap();
    test_both_strobes();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
